// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with req/ack memory handshake, one-entry skid buffer and redirect squash
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h00001000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk_i,
    input  logic        rsn_i,
    input  logic        stall_core_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] fetch_instr_o,
    output logic [31:0] fetch_pc_o,
    output logic        fetch_valid_o
);
    typedef enum logic [1:0] {IDLE, REQ, FULL, KILL} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, kill_addr_q, skid_instr_q, skid_pc_q, out_instr_q, out_pc_q;
    logic        out_valid_q;
    logic        ack, consumable, take_ack;
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) state_q <= IDLE;
        else        state_q <= state_d;
    end
    // A redirect with no ack this cycle leaves a response in flight that must be squashed
    always_comb begin
        state_d = state_q;
        if (redirect_i)
            state_d = (imem_req_o && !imem_ack_i) ? KILL : REQ;
        else if (state_q == IDLE)
            state_d = REQ;
        else if (state_q == REQ && ack && !consumable)
            state_d = FULL;
        else if (state_q == FULL && !stall_core_i)
            state_d = REQ;
        else if (state_q == KILL && ack)
            state_d = REQ;
    end
    always_comb begin
        imem_req_o    = (state_q == REQ) || (state_q == KILL);
        imem_addr_o   = (state_q == KILL) ? kill_addr_q : pc_q;
        ack           = imem_req_o && imem_ack_i;
        consumable    = !stall_core_i || !out_valid_q;
        take_ack      = (state_q == REQ) && ack && !redirect_i;
        fetch_instr_o = out_instr_q;
        fetch_pc_o    = out_pc_q;
        fetch_valid_o = out_valid_q;
    end
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            pc_q         <= RESET_PC;
            kill_addr_q  <= RESET_PC;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            out_instr_q  <= NOP_INSTR;
            out_pc_q     <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            if (redirect_i)    pc_q <= redirect_pc_i & ~32'd3;
            else if (take_ack) pc_q <= pc_q + 32'd4;
            if (redirect_i && state_q == REQ) kill_addr_q <= pc_q;
            if (take_ack && !consumable) begin
                skid_instr_q <= imem_data_i;
                skid_pc_q    <= pc_q;
            end
            // Bubbles keep the last pc so the decode side sees a stable value
            if (redirect_i) begin
                out_instr_q <= NOP_INSTR;
                out_valid_q <= 1'b0;
            end else if (state_q == FULL && !stall_core_i) begin
                out_instr_q <= skid_instr_q;
                out_pc_q    <= skid_pc_q;
                out_valid_q <= 1'b1;
            end else if (take_ack && consumable) begin
                out_instr_q <= imem_data_i;
                out_pc_q    <= pc_q;
                out_valid_q <= 1'b1;
            end else if (!stall_core_i) begin
                out_instr_q <= NOP_INSTR;
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus against a transaction-level fetch model with a variable-latency memory
module tb_fetch_unit;
    logic        clk_i = 1'b0;
    logic        rsn_i = 1'b0;
    logic        stall_core_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = '0;
    logic [31:0] fetch_instr_o;
    logic [31:0] fetch_pc_o;
    logic        fetch_valid_o;
    localparam logic [31:0] NOP = 32'h00000013;
    fetch_unit dut (
        .clk_i(clk_i), .rsn_i(rsn_i), .stall_core_i(stall_core_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
        .fetch_instr_o(fetch_instr_o), .fetch_pc_o(fetch_pc_o), .fetch_valid_o(fetch_valid_o)
    );
    always #5 clk_i = ~clk_i;
    int vectors = 0;
    int miscompares = 0;
    int lat = 0;
    int cnt = 0;
    bit dead_en = 1'b0;
    bit ack_force = 1'b0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask
    // Memory: acks after lat wait cycles, data = address unless poisoned
    always @(posedge clk_i) begin
        #2;
        if (ack_force) begin
            imem_ack_i = 1'b1;
            imem_data_i = 32'hBAD0BAD0;
            cnt = 0;
        end else if (!imem_req_o) begin
            imem_ack_i = 1'b0;
            cnt = 0;
        end else if (cnt >= lat) begin
            imem_ack_i = 1'b1;
            imem_data_i = dead_en ? 32'h0000DEAD : imem_addr_o;
            cnt = 0;
        end else begin
            imem_ack_i = 1'b0;
            cnt++;
        end
    end
    // Reference model: queue of accepted words awaiting display, expected next fetch address, squash flag
    typedef struct packed {logic [31:0] pc; logic [31:0] instr;} ent_t;
    ent_t        q[$];
    ent_t        e;
    logic [31:0] cur_pc = '0, cur_instr = NOP, next_pc = 32'h1000, kill_addr = '0;
    bit          cur_valid = 1'b0, killed = 1'b0;
    always @(negedge clk_i) begin
        if (!rsn_i) begin
            check("m_rst_req", 32'(imem_req_o), 0);
            check("m_rst_addr", imem_addr_o, 32'h1000);
            check("m_rst_valid", 32'(fetch_valid_o), 0);
            check("m_rst_pc", fetch_pc_o, 0);
            check("m_rst_instr", fetch_instr_o, NOP);
            q.delete();
            cur_pc = '0;
            cur_instr = NOP;
            cur_valid = 1'b0;
            next_pc = 32'h1000;
            killed = 1'b0;
        end else begin
            check("m_valid", 32'(fetch_valid_o), 32'(cur_valid));
            check("m_pc", fetch_pc_o, cur_pc);
            check("m_instr", fetch_instr_o, cur_valid ? cur_instr : NOP);
            if (imem_req_o) check("m_addr", imem_addr_o, killed ? kill_addr : next_pc);
            if (imem_req_o && imem_ack_i && !killed && !redirect_i) begin
                q.push_back('{pc: imem_addr_o, instr: imem_data_i});
                next_pc = next_pc + 32'd4;
            end
            if (redirect_i) begin
                q.delete();
                cur_valid = 1'b0;
                next_pc = redirect_pc_i & ~32'd3;
                if (imem_req_o && !imem_ack_i) begin
                    if (!killed) kill_addr = imem_addr_o;
                    killed = 1'b1;
                end else killed = 1'b0;
            end else begin
                if (imem_req_o && imem_ack_i) killed = 1'b0;
                if (!(stall_core_i && cur_valid)) begin
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        cur_pc = e.pc;
                        cur_instr = e.instr;
                        cur_valid = 1'b1;
                    end else cur_valid = 1'b0;
                end
            end
        end
    end
    initial begin
        tick(3);
        check("rst_req", 32'(imem_req_o), 0);
        check("rst_addr", imem_addr_o, 32'h1000);
        check("rst_instr", fetch_instr_o, NOP);
        check("rst_pc", fetch_pc_o, 0);
        check("rst_valid", 32'(fetch_valid_o), 0);
        rsn_i = 1'b1;
        check("idle_req", 32'(imem_req_o), 0);
        tick(1);
        check("req_rise", 32'(imem_req_o), 1);
        check("req_addr", imem_addr_o, 32'h1000);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("seq_valid", 32'(fetch_valid_o), 1);
            check("seq_pc", fetch_pc_o, 32'h1000 + 4 * i);
            check("seq_instr", fetch_instr_o, 32'h1000 + 4 * i);
        end
        rsn_i = 1'b0;
        lat = 3;
        tick(2);
        rsn_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("wait_req", 32'(imem_req_o), 1);
            check("wait_addr", imem_addr_o, 32'h1000);
            check("wait_valid", 32'(fetch_valid_o), 0);
            check("wait_instr", fetch_instr_o, NOP);
        end
        lat = 0;
        tick(1);
        check("wait_done_valid", 32'(fetch_valid_o), 1);
        check("wait_done_pc", fetch_pc_o, 32'h1000);
        tick(1);
        stall_core_i = 1'b1;
        check("stall_pc0", fetch_pc_o, 32'h1004);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("stall_hold_pc", fetch_pc_o, 32'h1004);
            check("stall_full_req", 32'(imem_req_o), 0);
            check("stall_hold_valid", 32'(fetch_valid_o), 1);
        end
        tick(1);
        stall_core_i = 1'b0;
        check("stall_last_pc", fetch_pc_o, 32'h1004);
        tick(1);
        check("unstall_pc", fetch_pc_o, 32'h1008);
        check("unstall_req", 32'(imem_req_o), 1);
        check("unstall_addr", imem_addr_o, 32'h100C);
        tick(1);
        check("unstall_pc2", fetch_pc_o, 32'h100C);
        lat = 2;
        dead_en = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h2002;
        tick(1);
        redirect_i = 1'b0;
        check("kill_valid", 32'(fetch_valid_o), 0);
        check("kill_instr", fetch_instr_o, NOP);
        check("kill_req", 32'(imem_req_o), 1);
        check("kill_addr", imem_addr_o, 32'h1010);
        tick(1);
        check("kill_addr_held", imem_addr_o, 32'h1010);
        tick(1);
        dead_en = 1'b0;
        lat = 0;
        check("redir_req", 32'(imem_req_o), 1);
        check("redir_addr", imem_addr_o, 32'h2000);
        check("redir_bubble", 32'(fetch_valid_o), 0);
        tick(1);
        check("redir_valid", 32'(fetch_valid_o), 1);
        check("redir_pc", fetch_pc_o, 32'h2000);
        check("redir_instr", fetch_instr_o, 32'h2000);
        stall_core_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h3000;
        tick(1);
        stall_core_i = 1'b0;
        redirect_i = 1'b0;
        check("coinc_valid", 32'(fetch_valid_o), 0);
        check("coinc_instr", fetch_instr_o, NOP);
        check("coinc_req", 32'(imem_req_o), 1);
        check("coinc_addr", imem_addr_o, 32'h3000);
        tick(1);
        check("coinc_pc", fetch_pc_o, 32'h3000);
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFFFFF8;
        tick(1);
        redirect_i = 1'b0;
        check("wrap_addr", imem_addr_o, 32'hFFFFFFF8);
        tick(1);
        check("wrap_pc0", fetch_pc_o, 32'hFFFFFFF8);
        tick(1);
        check("wrap_pc1", fetch_pc_o, 32'hFFFFFFFC);
        check("wrap_addr0", imem_addr_o, 32'h0);
        tick(1);
        check("wrap_pc2", fetch_pc_o, 32'h0);
        check("wrap_valid", 32'(fetch_valid_o), 1);
        lat = 5;
        tick(1);
        rsn_i = 1'b0;
        ack_force = 1'b1;
        #1;
        check("mid_rst_req", 32'(imem_req_o), 0);
        check("mid_rst_addr", imem_addr_o, 32'h1000);
        check("mid_rst_valid", 32'(fetch_valid_o), 0);
        check("mid_rst_pc", fetch_pc_o, 0);
        check("mid_rst_instr", fetch_instr_o, NOP);
        tick(2);
        check("rst_ack_req", 32'(imem_req_o), 0);
        check("rst_ack_valid", 32'(fetch_valid_o), 0);
        ack_force = 1'b0;
        lat = 0;
        rsn_i = 1'b1;
        check("restart_idle", 32'(imem_req_o), 0);
        tick(1);
        check("restart_req", 32'(imem_req_o), 1);
        check("restart_addr", imem_addr_o, 32'h1000);
        tick(1);
        check("restart_pc", fetch_pc_o, 32'h1000);
        check("restart_valid", 32'(fetch_valid_o), 1);
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
